// File: rtl/conway_pkg.sv
// rtl/conway_pkg.sv - shared widths and FSM encoding for the Life sequencer
//
// Default grid/counter widths and the sequencer state encoding. States are
// plain logic constants so older netlists and waveform decoders that expect
// a fixed 3-bit encoding keep working.
package conway_pkg;

  localparam int ROWS_DEF  = 8;   // grid rows, one row word per handshake
  localparam int COLS_DEF  = 8;   // grid columns, width of one row word
  localparam int GEN_W_DEF = 16;  // generation counter / limit width
  localparam int DIV_W_DEF = 16;  // step divider width

  typedef logic [2:0] seq_state_t;

  localparam seq_state_t ST_LOAD   = 3'd0;  // accepting rows into the shadow register
  localparam seq_state_t ST_COMMIT = 3'd1;  // one-cycle core capture of the shadow
  localparam seq_state_t ST_ARMED  = 3'd2;  // pattern in core, waiting for START
  localparam seq_state_t ST_RUN    = 3'd3;  // issuing generations
  localparam seq_state_t ST_HALT   = 3'd4;  // stopped, stable or limit reached

endpackage

// File: rtl/conway_seq_ctrl_if.sv
// rtl/conway_seq_ctrl_if.sv - row stream valid/ready interface into the sequencer
//
// Signals:
//   ROW_DATA  - one grid row, bit c is column c
//   ROW_VALID - source has a row on ROW_DATA
//   ROW_READY - sequencer can take a row this cycle
// Modports: master = row source, slave = sequencer.
interface conway_seq_ctrl_if
  import conway_pkg::*;
#(
  parameter int DATA_W = COLS_DEF
) ();

  logic [DATA_W-1:0] ROW_DATA;
  logic              ROW_VALID;
  logic              ROW_READY;

  modport master (output ROW_DATA, output ROW_VALID, input ROW_READY);
  modport slave  (input ROW_DATA, input ROW_VALID, output ROW_READY);

endinterface

// File: rtl/conway_row_loader.sv
// rtl/conway_row_loader.sv - row index counter and shadow pattern register
//
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   wr_en      - a row transfers this cycle
//   clr        - restart row indexing at row 0 (shadow keeps its contents)
//   row_data   - incoming row word
//   shadow     - assembled pattern, row r at shadow[COLS*r +: COLS]
//   last_row   - the next transfer completes the pattern
module conway_row_loader
  import conway_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic                 clr,
  input  logic [COLS-1:0]      row_data,
  output logic [ROWS*COLS-1:0] shadow,
  output logic                 last_row
);

  localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [IDX_W-1:0] row_idx;

  assign last_row = (row_idx == IDX_W'(ROWS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_idx <= '0;
      shadow  <= '0;
    end else if (clr) begin
      row_idx <= '0;
    end else if (wr_en) begin
      shadow[COLS*row_idx +: COLS] <= row_data;
      // Wrapping on the last row leaves the index ready for the next reload.
      row_idx <= last_row ? '0 : row_idx + 1'b1;
    end
  end

endmodule

// File: rtl/conway_seq_ctrl.sv
// rtl/conway_seq_ctrl.sv - load/commit/run sequencer for the 8x8 Life core
//
// Ports:
//   CLK, RESET_N          - clock, asynchronous active-low reset
//   row_if (slave)        - ROW_DATA/ROW_VALID/ROW_READY row stream
//   START, STOP, RELOAD   - one-cycle control pulses
//   STEP_DIV              - cycles per generation (0 behaves as 1)
//   MAX_GEN               - generation limit (0 = unlimited)
//   CURRENT_STATE         - core memory contents
//   NEXT_STATE            - core's next-generation value
//   INITIAL_STATE         - shadow pattern driven to the core
//   LOAD_RUN              - 0 = core loads INITIAL_STATE, 1 = core evolves
//   CLK_EN                - core clock gate, changes only while CLK is low
//   GEN_COUNT             - generations issued since the last commit
//   RUNNING               - sequencer is in RUN
//   STABLE                - halted because the pattern stopped changing
module conway_seq_ctrl
  import conway_pkg::*;
#(
  parameter int ROWS  = ROWS_DEF,
  parameter int COLS  = COLS_DEF,
  parameter int GEN_W = GEN_W_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  conway_seq_ctrl_if.slave     row_if,
  input  logic                 START,
  input  logic                 STOP,
  input  logic                 RELOAD,
  input  logic [DIV_W-1:0]     STEP_DIV,
  input  logic [GEN_W-1:0]     MAX_GEN,
  input  logic [ROWS*COLS-1:0] CURRENT_STATE,
  input  logic [ROWS*COLS-1:0] NEXT_STATE,
  output logic [ROWS*COLS-1:0] INITIAL_STATE,
  output logic                 LOAD_RUN,
  output logic                 CLK_EN,
  output logic [GEN_W-1:0]     GEN_COUNT,
  output logic                 RUNNING,
  output logic                 STABLE
);

  seq_state_t       state;
  logic             en_req;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_last;
  logic             row_fire;
  logic             last_row;
  logic             reload_go;
  logic             step_due;
  logic             pattern_stable;
  logic [GEN_W-1:0] gen_inc;
  logic             limit_after_step;
  logic             limit_hit;

  assign row_if.ROW_READY = (state == ST_LOAD);
  assign RUNNING          = (state == ST_RUN);
  assign row_fire         = row_if.ROW_VALID & row_if.ROW_READY;

  assign reload_go = RELOAD &
                     ((state == ST_ARMED) | (state == ST_RUN) | (state == ST_HALT));

  // >= rather than == so a STEP_DIV lowered mid-run cannot strand the divider
  // above its new terminal count.
  assign div_last = (STEP_DIV == '0) ? '0 : STEP_DIV - 1'b1;
  assign step_due = (div_cnt >= div_last);

  assign pattern_stable = (NEXT_STATE == CURRENT_STATE);

  assign gen_inc          = (&GEN_COUNT) ? GEN_COUNT : GEN_COUNT + 1'b1;
  assign limit_after_step = (MAX_GEN != '0) && (gen_inc >= MAX_GEN);
  assign limit_hit        = (MAX_GEN != '0) && (GEN_COUNT >= MAX_GEN);

  conway_row_loader #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_row_loader (
    .clk      (CLK),
    .rst_n    (RESET_N),
    .wr_en    (row_fire),
    .clr      (reload_go),
    .row_data (row_if.ROW_DATA),
    .shadow   (INITIAL_STATE),
    .last_row (last_row)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= ST_LOAD;
      en_req    <= 1'b0;
      div_cnt   <= '0;
      GEN_COUNT <= '0;
      LOAD_RUN  <= 1'b0;
      STABLE    <= 1'b0;
    end else begin
      en_req <= 1'b0;
      if (reload_go) begin
        state     <= ST_LOAD;
        div_cnt   <= '0;
        GEN_COUNT <= '0;
        LOAD_RUN  <= 1'b0;
        STABLE    <= 1'b0;
      end else begin
        case (state)
          ST_LOAD: begin
            if (row_fire && last_row) begin
              // The commit pulse is raised on the same edge the pattern
              // completes, so the core captures one edge later while
              // LOAD_RUN is still 0.
              state     <= ST_COMMIT;
              en_req    <= 1'b1;
              GEN_COUNT <= '0;
            end
          end
          ST_COMMIT: begin
            state    <= ST_ARMED;
            LOAD_RUN <= 1'b1;
          end
          ST_ARMED: begin
            if (START) begin
              state   <= ST_RUN;
              div_cnt <= '0;
            end
          end
          ST_RUN: begin
            if (STOP) begin
              state <= ST_HALT;
            end else if (step_due) begin
              div_cnt <= '0;
              if (pattern_stable) begin
                STABLE <= 1'b1;
                state  <= ST_HALT;
              end else begin
                en_req    <= 1'b1;
                GEN_COUNT <= gen_inc;
                if (limit_after_step) begin
                  state <= ST_HALT;
                end
              end
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
          ST_HALT: begin
            if (START && !STABLE && !limit_hit) begin
              state   <= ST_RUN;
              div_cnt <= '0;
            end
          end
          default: begin
            state    <= ST_LOAD;
            LOAD_RUN <= 1'b0;
          end
        endcase
      end
    end
  end

  // Re-timing en_req onto the falling edge keeps CLK & CLK_EN free of
  // glitches: the enable only moves while CLK is low.
  always_ff @(negedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      CLK_EN <= 1'b0;
    end else begin
      CLK_EN <= en_req;
    end
  end

endmodule
